// File: rtl/rv_multicycle_sequencer.sv
// Control sequencer for the multicycle RISC-V core: fetch/decode/execute/mem/writeback
// with a req/ack memory handshake, timeout, fault capture, single-step and retire counter.
module rv_multicycle_sequencer #(
   parameter int unsigned          WORD_SIZE      = 32,
   parameter logic [WORD_SIZE-1:0] RESET_PC       = {WORD_SIZE{1'b0}},
   parameter int unsigned          TIMEOUT_CYCLES = 15,
   parameter logic [6:0]           HALT_OPCODE    = 7'b1111111
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic                 step_mode,
   input  logic                 step,
   output logic                 mem_req,
   output logic [1:0]           mem_write,
   output logic [WORD_SIZE-1:0] mem_addr,
   input  logic                 mem_ack,
   input  logic                 mem_err,
   input  logic [WORD_SIZE-1:0] mem_rdata,
   output logic [WORD_SIZE-1:0] instruction,
   input  logic                 decode_error,
   input  logic                 mem_to_reg,
   input  logic [1:0]           mem_write_size,
   input  logic [WORD_SIZE-1:0] alu_result,
   input  logic [WORD_SIZE-1:0] next_pc,
   output logic [WORD_SIZE-1:0] pc,
   output logic [WORD_SIZE-1:0] load_data,
   output logic                 reg_we,
   output logic [3:0]           state,
   output logic                 halted,
   output logic                 fault,
   output logic [1:0]           fault_cause,
   output logic [WORD_SIZE-1:0] instret
);

   localparam int unsigned          TW        = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]        TMO_LIMIT = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]        TMO_ZERO  = {TW{1'b0}};
   localparam logic [WORD_SIZE-1:0] WORD_ZERO = {WORD_SIZE{1'b0}};
   localparam logic [WORD_SIZE-1:0] WORD_ONE  = {{(WORD_SIZE-1){1'b0}}, 1'b1};

   localparam logic [1:0] CAUSE_DECODE  = 2'd0;
   localparam logic [1:0] CAUSE_MEMERR  = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
   localparam logic [1:0] CAUSE_MISALGN = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_EXECUTE   = 4'd3,
      S_MEM       = 4'd4,
      S_WRITEBACK = 4'd5,
      S_PAUSE     = 4'd6,
      S_HALT      = 4'd9,
      S_FAULT     = 4'd15
   } state_e;

   state_e                 state_r;
   logic [TW-1:0]          tmo_cnt_r;
   logic                   is_store_s;
   logic                   is_mem_op_s;
   logic                   timed_out_s;
   logic [WORD_SIZE-1:0]   fetch_addr_s;

   function automatic logic word_aligned(input logic [1:0] lsbs);
      return (lsbs == 2'b00);
   endfunction

   assign state = state_r;

   // Decode helpers; a fetch entered from WRITEBACK targets the PC being loaded
   always_comb begin
      is_store_s  = (mem_write_size != 2'b00);
      is_mem_op_s = mem_to_reg || is_store_s;
      timed_out_s = (tmo_cnt_r == TMO_LIMIT);
      if (state_r == S_WRITEBACK) begin
         fetch_addr_s = next_pc;
      end else begin
         fetch_addr_s = pc;
      end
   end

   // Sequencer state machine with all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         tmo_cnt_r   <= TMO_ZERO;
         pc          <= RESET_PC;
         instruction <= WORD_ZERO;
         load_data   <= WORD_ZERO;
         instret     <= WORD_ZERO;
         fault_cause <= CAUSE_DECODE;
         mem_req     <= 1'b0;
         mem_write   <= 2'b00;
         mem_addr    <= WORD_ZERO;
         reg_we      <= 1'b0;
         halted      <= 1'b0;
         fault       <= 1'b0;
      end else begin
         reg_we <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (run) begin
                  state_r   <= S_FETCH;
                  tmo_cnt_r <= TMO_ZERO;
                  mem_req   <= word_aligned(fetch_addr_s[1:0]);
                  mem_addr  <= fetch_addr_s;
                  mem_write <= 2'b00;
               end
            end
            S_FETCH: begin
               // A misaligned PC never raised mem_req on entry
               if (!word_aligned(pc[1:0])) begin
                  state_r     <= S_FAULT;
                  fault       <= 1'b1;
                  fault_cause <= CAUSE_MISALGN;
                  mem_req     <= 1'b0;
               end else if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (mem_err) begin
                     state_r     <= S_FAULT;
                     fault       <= 1'b1;
                     fault_cause <= CAUSE_MEMERR;
                  end else begin
                     instruction <= mem_rdata;
                     state_r     <= S_DECODE;
                  end
               end else if (timed_out_s) begin
                  mem_req     <= 1'b0;
                  state_r     <= S_FAULT;
                  fault       <= 1'b1;
                  fault_cause <= CAUSE_TIMEOUT;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TW'(1'b1);
               end
            end
            S_DECODE: begin
               state_r <= S_EXECUTE;
            end
            S_EXECUTE: begin
               if (instruction[6:0] == HALT_OPCODE) begin
                  state_r <= S_HALT;
                  halted  <= 1'b1;
               end else if (decode_error) begin
                  state_r     <= S_FAULT;
                  fault       <= 1'b1;
                  fault_cause <= CAUSE_DECODE;
               end else if (is_mem_op_s) begin
                  state_r   <= S_MEM;
                  tmo_cnt_r <= TMO_ZERO;
                  mem_req   <= 1'b1;
                  mem_addr  <= alu_result;
                  mem_write <= mem_write_size;
               end else begin
                  state_r <= S_WRITEBACK;
                  reg_we  <= 1'b1;
               end
            end
            S_MEM: begin
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  mem_write <= 2'b00;
                  if (mem_err) begin
                     state_r     <= S_FAULT;
                     fault       <= 1'b1;
                     fault_cause <= CAUSE_MEMERR;
                  end else begin
                     if (mem_to_reg) begin
                        load_data <= mem_rdata;
                     end
                     reg_we  <= !is_store_s;
                     state_r <= S_WRITEBACK;
                  end
               end else if (timed_out_s) begin
                  mem_req     <= 1'b0;
                  mem_write   <= 2'b00;
                  state_r     <= S_FAULT;
                  fault       <= 1'b1;
                  fault_cause <= CAUSE_TIMEOUT;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TW'(1'b1);
               end
            end
            S_WRITEBACK: begin
               pc      <= next_pc;
               instret <= instret + WORD_ONE;
               if (step_mode) begin
                  state_r <= S_PAUSE;
               end else begin
                  state_r   <= S_FETCH;
                  tmo_cnt_r <= TMO_ZERO;
                  mem_req   <= word_aligned(fetch_addr_s[1:0]);
                  mem_addr  <= fetch_addr_s;
                  mem_write <= 2'b00;
               end
            end
            S_PAUSE: begin
               if (step || !step_mode) begin
                  state_r   <= S_FETCH;
                  tmo_cnt_r <= TMO_ZERO;
                  mem_req   <= word_aligned(fetch_addr_s[1:0]);
                  mem_addr  <= fetch_addr_s;
                  mem_write <= 2'b00;
               end
            end
            S_HALT, S_FAULT: begin
               mem_req   <= 1'b0;
               mem_write <= 2'b00;
            end
            default: begin
               // Corrupted state register: park safely with the bus idle
               state_r   <= S_FAULT;
               fault     <= 1'b1;
               mem_req   <= 1'b0;
               mem_write <= 2'b00;
            end
         endcase
      end
   end

endmodule
